// File: rtl/di_arbiter_pkg.sv
// di_arb_pkg: shared types for the two-master device-interface arbiter.
// State encodings and master index constants.
package di_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

endpackage

// File: rtl/di_arbiter_if.sv
// di_arbiter_if: one master's view of the 16-bit device (register) interface.
// The master modport is the requester side; the slave modport is the arbiter side.
interface di_arbiter_if #(parameter int DW = 16);

   logic          req;
   logic          gnt;
   logic [DW-1:0] ep_addr;
   logic [DW-1:0] reg_addr;
   logic [DW-1:0] data_in;
   logic          write;
   logic          read;
   logic [DW-1:0] data_out;
   logic          rd_ready;
   logic          wr_ready;
   logic          timeout;

   modport master (
      output req, ep_addr, reg_addr, data_in, write, read,
      input  gnt, data_out, rd_ready, wr_ready, timeout
   );

   modport slave (
      input  req, ep_addr, reg_addr, data_in, write, read,
      output gnt, data_out, rd_ready, wr_ready, timeout
   );

endinterface

// File: rtl/di_arb_timeout.sv
// di_arb_timeout: strobe-without-ready watchdog for the arbiter.
// Only compiled when DI_ARB_TIMEOUT_EN is defined. hit is asserted in the
// cycle where the counter has already seen TIMEOUT_CYCLES-1 stalled cycles
// and the strobe is still stalled.
`ifdef DI_ARB_TIMEOUT_EN
module di_arb_timeout #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic if_clock,
   input  logic resetb,
   input  logic clr,
   input  logic inc,
   output logic hit
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CW-1:0] cnt_q;

   assign hit = inc && !clr && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   // stall counter: cleared by grant loss/ready/expiry, counts stalled strobe cycles
   always_ff @(posedge if_clock or negedge resetb) begin
      if (!resetb)
         cnt_q <= '0;
      else if (clr || hit)
         cnt_q <= '0;
      else if (inc)
         cnt_q <= cnt_q + CW'(1);
   end

endmodule
`endif

// File: rtl/di_arbiter.sv
// di_arbiter: two-master arbiter for the 16-bit device interface.
// Master 0 = host register port, master 1 = on-chip requester. One grant at a
// time, round robin on ties, no preemption, at least one IDLE cycle between
// grants. Granted master's fields/strobes are registered onto the di_* bus.
// Optional watchdog: define DI_ARB_TIMEOUT_EN to abort a strobe that sees no
// ready for TIMEOUT_CYCLES cycles.
module di_arbiter
   import di_arb_pkg::*;
#(
   parameter int DW             = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic          if_clock,
   input  logic          resetb,
   di_arbiter_if.slave   m0,
   di_arbiter_if.slave   m1,
   output logic [DW-1:0] di_ep_addr,
   output logic [DW-1:0] di_reg_addr,
   output logic [DW-1:0] di_data_in,
   output logic          di_write,
   output logic          di_read,
   input  logic [DW-1:0] di_data_out,
   input  logic          rd_ready,
   input  logic          wr_ready
);

   arb_state_e           state_q, state_d;
   logic                 last_gnt_q, last_gnt_d;
   logic [1:0]           req, wr, rd;
   logic [1:0][DW-1:0]   ep, ra, wd;
   logic                 sel, granted;
   logic                 wr_nxt, rd_nxt;
   logic                 tmo_any;

   assign req = {m1.req, m0.req};
   assign wr  = {m1.write, m0.write};
   assign rd  = {m1.read, m0.read};
   assign ep  = {m1.ep_addr, m0.ep_addr};
   assign ra  = {m1.reg_addr, m0.reg_addr};
   assign wd  = {m1.data_in, m0.data_in};

   assign sel     = (state_q == GNT1) ? M1 : M0;
   assign granted = (state_q != IDLE);

   // next-state / arbitration; strobe hand-off to the registered bus
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      wr_nxt     = 1'b0;
      rd_nxt     = 1'b0;
      case (state_q)
         IDLE: begin
            if (req[0] && req[1]) begin
               if (last_gnt_q == M0) begin
                  state_d    = GNT1;
                  last_gnt_d = M1;
               end else begin
                  state_d    = GNT0;
                  last_gnt_d = M0;
               end
            end else if (req[0]) begin
               state_d    = GNT0;
               last_gnt_d = M0;
            end else if (req[1]) begin
               state_d    = GNT1;
               last_gnt_d = M1;
            end
         end
         GNT0, GNT1: begin
            // release only once nothing is in flight on the bus
            if (tmo_any || (!req[sel] && !di_write && !di_read))
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // a strobe completed this cycle is dropped so it cannot be replayed
      // while the master is still lowering its level strobe
      if (granted && (state_d == state_q)) begin
         wr_nxt = wr[sel] && !(di_write && wr_ready);
         rd_nxt = rd[sel] && !(di_read && rd_ready);
      end
   end

   // state, round-robin history and registered di_* bus
   always_ff @(posedge if_clock or negedge resetb) begin
      if (!resetb) begin
         state_q     <= IDLE;
         last_gnt_q  <= M1;
         di_ep_addr  <= '0;
         di_reg_addr <= '0;
         di_data_in  <= '0;
         di_write    <= 1'b0;
         di_read     <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         di_write   <= wr_nxt;
         di_read    <= rd_nxt;
         if (granted) begin
            di_ep_addr  <= ep[sel];
            di_reg_addr <= ra[sel];
            di_data_in  <= wd[sel];
         end
      end
   end

   assign m0.gnt      = (state_q == GNT0);
   assign m1.gnt      = (state_q == GNT1);
   assign m0.data_out = m0.gnt ? di_data_out : '0;
   assign m1.data_out = m1.gnt ? di_data_out : '0;
   assign m0.rd_ready = rd_ready && m0.gnt;
   assign m1.rd_ready = rd_ready && m1.gnt;
   assign m0.wr_ready = wr_ready && m0.gnt;
   assign m1.wr_ready = wr_ready && m1.gnt;

`ifdef DI_ARB_TIMEOUT_EN
   logic       tmo_clr, tmo_inc;
   logic [1:0] tmo_q;

   assign tmo_clr = !granted || (di_write && wr_ready) || (di_read && rd_ready);
   assign tmo_inc = (di_write && !wr_ready) || (di_read && !rd_ready);

   di_arb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
      .if_clock (if_clock),
      .resetb   (resetb),
      .clr      (tmo_clr),
      .inc      (tmo_inc),
      .hit      (tmo_any)
   );

   // one-cycle abort pulse to the master that owned the stalled strobe
   always_ff @(posedge if_clock or negedge resetb) begin
      if (!resetb)
         tmo_q <= '0;
      else
         tmo_q <= {tmo_any && (sel == M1), tmo_any && (sel == M0)};
   end

   assign m0.timeout = tmo_q[0];
   assign m1.timeout = tmo_q[1];
`else
   assign tmo_any    = 1'b0;
   assign m0.timeout = 1'b0;
   assign m1.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_di_arbiter.sv
// tb_di_arbiter: directed bench for di_arbiter. Bus accesses are pushed to a
// scoreboard when driven and popped when the strobe first appears on di_*.
module tb_di_arbiter;

   localparam int DW = 16;

   logic          if_clock = 1'b0;
   logic          resetb;
   logic [DW-1:0] di_ep_addr, di_reg_addr, di_data_in, di_data_out;
   logic          di_write, di_read, rd_ready, wr_ready;

   di_arbiter_if #(.DW(DW)) m0_if ();
   di_arbiter_if #(.DW(DW)) m1_if ();

   di_arbiter #(.DW(DW), .TIMEOUT_CYCLES(16)) dut (
      .if_clock    (if_clock),
      .resetb      (resetb),
      .m0          (m0_if),
      .m1          (m1_if),
      .di_ep_addr  (di_ep_addr),
      .di_reg_addr (di_reg_addr),
      .di_data_in  (di_data_in),
      .di_write    (di_write),
      .di_read     (di_read),
      .di_data_out (di_data_out),
      .rd_ready    (rd_ready),
      .wr_ready    (wr_ready)
   );

   always #5 if_clock = ~if_clock;

   typedef struct packed {
      logic          wr;
      logic          rd;
      logic [DW-1:0] ep;
      logic [DW-1:0] ra;
      logic [DW-1:0] wd;
   } acc_t;

   acc_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   logic strb_prev = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge if_clock);
      #1;
   endtask

   // scoreboard monitor: each new strobe on the bus must match the next queued access
   always @(negedge if_clock) begin
      if (!resetb) begin
         strb_prev <= 1'b0;
      end else begin
         if ((di_write || di_read) && !strb_prev) begin
            chk("sb_pending", 64'(sbq.size() != 0), 64'(1));
            if (sbq.size() != 0) begin
               acc_t exp_a, obs_a;
               exp_a = sbq.pop_front();
               obs_a = '{di_write, di_read, di_ep_addr, di_reg_addr, di_data_in};
               chk("sb_access", 64'(obs_a), 64'(exp_a));
            end
         end
         strb_prev <= di_write || di_read;
      end
   end

   initial begin
      int n;
      resetb = 1'b1;
      {m0_if.req, m0_if.write, m0_if.read} = '0;
      {m1_if.req, m1_if.write, m1_if.read} = '0;
      {m0_if.ep_addr, m0_if.reg_addr, m0_if.data_in} = '0;
      {m1_if.ep_addr, m1_if.reg_addr, m1_if.data_in} = '0;
      di_data_out = '0;
      rd_ready    = 1'b0;
      wr_ready    = 1'b0;
      #2 resetb = 1'b0;
      repeat (2) @(posedge if_clock);
      #1;
      chk("rst_gnt", {m0_if.gnt, m1_if.gnt}, 2'b00);
      chk("rst_di", {di_write, di_read, di_ep_addr, di_reg_addr, di_data_in}, '0);
      chk("rst_timeout", {m0_if.timeout, m1_if.timeout}, 2'b00);
      resetb = 1'b1;

      // m0 write, wr_ready three cycles into the access
      m0_if.req = 1'b1; m0_if.write = 1'b1;
      m0_if.ep_addr = 16'h0001; m0_if.reg_addr = 16'h0010; m0_if.data_in = 16'hBEEF;
      sbq.push_back('{1'b1, 1'b0, 16'h0001, 16'h0010, 16'hBEEF});
      cyc();
      chk("t1_gnt", {m0_if.gnt, m1_if.gnt}, 2'b10);
      chk("t1_no_strobe_yet", di_write, 1'b0);
      cyc();
      chk("t1_di_write", di_write, 1'b1);
      chk("t1_fields", {di_ep_addr, di_reg_addr, di_data_in}, {16'h0001, 16'h0010, 16'hBEEF});
      cyc(); cyc();
      wr_ready = 1'b1;
      #1;
      chk("t1_m0_wr_ready", m0_if.wr_ready, 1'b1);
      chk("t1_m1_wr_ready", m1_if.wr_ready, 1'b0);
      cyc();
      m0_if.write = 1'b0; wr_ready = 1'b0;
      chk("t1_strobe_done", di_write, 1'b0);
      chk("t1_gnt_held", m0_if.gnt, 1'b1);
      m0_if.req = 1'b0;
      cyc();
      chk("t1_release", m0_if.gnt, 1'b0);
      chk("t1_no_timeout", m0_if.timeout, 1'b0);

      // simultaneous requests from reset, then round robin
      resetb = 1'b0;
      cyc();
      resetb = 1'b1;
      m0_if.req = 1'b1; m1_if.req = 1'b1;
      cyc();
      chk("t2_first", {m0_if.gnt, m1_if.gnt}, 2'b10);
      cyc(); cyc();
      chk("t2_no_preempt", {m0_if.gnt, m1_if.gnt}, 2'b10);
      m0_if.req = 1'b0;
      cyc();
      chk("t2_idle", {m0_if.gnt, m1_if.gnt}, 2'b00);
      cyc();
      chk("t2_m1", {m0_if.gnt, m1_if.gnt}, 2'b01);
      m1_if.req = 1'b0;
      cyc();
      chk("t2_idle2", {m0_if.gnt, m1_if.gnt}, 2'b00);
      m0_if.req = 1'b1; m1_if.req = 1'b1;
      cyc();
      chk("t2_rr", {m0_if.gnt, m1_if.gnt}, 2'b10);
      m0_if.req = 1'b0; m1_if.req = 1'b0;
      cyc();
      chk("t2_idle3", {m0_if.gnt, m1_if.gnt}, 2'b00);

      // m1 read; m1 drops req with the read pending while m0 waits
      m1_if.req = 1'b1; m1_if.read = 1'b1;
      m1_if.ep_addr = 16'h0003; m1_if.reg_addr = 16'h0020; m1_if.data_in = 16'h0000;
      sbq.push_back('{1'b0, 1'b1, 16'h0003, 16'h0020, 16'h0000});
      cyc();
      chk("t3_gnt", {m0_if.gnt, m1_if.gnt}, 2'b01);
      cyc();
      chk("t3_di_read", di_read, 1'b1);
      m1_if.req = 1'b0; m0_if.req = 1'b1;
      cyc();
      chk("t4_hold", {m0_if.gnt, m1_if.gnt}, 2'b01);
      cyc();
      chk("t4_hold2", {m0_if.gnt, m1_if.gnt}, 2'b01);
      di_data_out = 16'h1234; rd_ready = 1'b1;
      #1;
      chk("t3_m1_data", m1_if.data_out, 16'h1234);
      chk("t3_m1_rd_ready", m1_if.rd_ready, 1'b1);
      chk("t3_m0_data", m0_if.data_out, 16'h0000);
      chk("t3_m0_rd_ready", m0_if.rd_ready, 1'b0);
      cyc();
      m1_if.read = 1'b0; rd_ready = 1'b0; di_data_out = '0;
      chk("t4_after_ready", {m0_if.gnt, m1_if.gnt, di_read}, 3'b010);
      cyc();
      chk("t4_idle", {m0_if.gnt, m1_if.gnt}, 2'b00);
      cyc();
      chk("t4_m0", {m0_if.gnt, m1_if.gnt}, 2'b10);

      // asynchronous reset in the middle of an m0 write
      m0_if.write = 1'b1;
      m0_if.ep_addr = 16'h0005; m0_if.reg_addr = 16'h0050; m0_if.data_in = 16'hA5A5;
      sbq.push_back('{1'b1, 1'b0, 16'h0005, 16'h0050, 16'hA5A5});
      cyc();
      chk("t5_write", di_write, 1'b1);
      @(negedge if_clock);
      #1;
      wr_ready = 1'b1;
      #1;
      chk("t5_ready_before", m0_if.wr_ready, 1'b1);
      resetb = 1'b0;
      #1;
      chk("t5_rst_gnt", {m0_if.gnt, m1_if.gnt}, 2'b00);
      chk("t5_rst_di", {di_write, di_read, di_ep_addr, di_reg_addr, di_data_in}, '0);
      chk("t5_rst_ready", m0_if.wr_ready, 1'b0);
      m0_if.req = 1'b0; m0_if.write = 1'b0; wr_ready = 1'b0;
      cyc();
      resetb = 1'b1;
      cyc();
      chk("t5_post_idle", {m0_if.gnt, m1_if.gnt}, 2'b00);
      m0_if.req = 1'b1; m1_if.req = 1'b1;
      cyc();
      chk("t5_post_arb", {m0_if.gnt, m1_if.gnt}, 2'b10);

      // m0 write to an endpoint that never answers, m1 waiting
      m0_if.write = 1'b1;
      m0_if.ep_addr = 16'h0007; m0_if.reg_addr = 16'h0070; m0_if.data_in = 16'h1111;
      sbq.push_back('{1'b1, 1'b0, 16'h0007, 16'h0070, 16'h1111});
      cyc();
      chk("t6_write", di_write, 1'b1);
`ifdef DI_ARB_TIMEOUT_EN
      n = 0;
      while (n < 40) begin
         cyc();
         n++;
         if (m0_if.timeout) break;
      end
      chk("t6_cycles", n, 16);
      chk("t6_abort", {di_write, m0_if.gnt, m1_if.gnt}, 3'b000);
      m0_if.req = 1'b0; m0_if.write = 1'b0;
      cyc();
      chk("t6_pulse", m0_if.timeout, 1'b0);
      chk("t6_m1", {m0_if.gnt, m1_if.gnt}, 2'b01);
`else
      n = 0;
      repeat (40) begin
         cyc();
         n += int'(m0_if.timeout);
      end
      chk("t6_no_timeout", n, 0);
      chk("t6_held", {m0_if.gnt, m1_if.gnt, di_write}, 3'b101);
`endif

      chk("sb_empty", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
